seg_scan_n: RTL and testbench
=============================

# seg_scan_n

Parametrised multiplexed seven-segment scanner driving `DIGITS` common-select digits from one scan clock. It is the successor of the fixed 4-digit scanner and adds:
- double-buffered display data with a load handshake committed only at frame boundaries, so no digit ever tears;
- per-digit blink;
- registered, phase-aligned `seg`/`an` outputs;
- optional leading-zero blanking.

It sits between the application datapath (counters, clocks, timers) and the board's segment/anode pins.

## Interface
- `DIGITS`, 4, number of scanned digits, legal 2..8.
- `BLINK_DIV`, 500, scan-clock cycles per blink half-period, legal ≥ 2; 500 gives 1 Hz blink at 1 kHz.
- `clk_1kHz`  input  1  scan clock, one digit slot per cycle.
- `rst_`  input  1  asynchronous, active-low reset.
- `load`  input  1  single-cycle strobe; captures `bin`, `dpin`, `en`, `blink` into staging.
- `bin`  input  4*DIGITS  packed hex nibbles; digit i = `bin[4i+3:4i]`.
- `dpin`  input  DIGITS  decimal point per digit, 1 = lit.
- `en`  input  DIGITS  digit enable, 1 = digit may light.
- `blink`  input  DIGITS  blink mask, 1 = digit blinks.
- `pending`  output  1  staged data is waiting for commit.
- `frame_done`  output  1  one-cycle pulse on the cycle digit DIGITS-1 is driven.
- `seg`  output  8  `seg[7]` = dp, `seg[6:0]` = a..g; a = bit 6; 1 = lit.
- `an`  output  DIGITS  digit select, active-high, at most one bit set.

## Operation
- **Scan counter.** `cnt` has width `$clog2(DIGITS)`. It counts 0..DIGITS-1, then wraps to 0. It advances on every clock.
- **Shadow registers.** `sh_bin`, `sh_dp`, `sh_en` and `sh_blink` hold the displayed data. They change only at a commit.
- **Staging and commit.**
  - A `load` strobe writes the inputs into staging and sets `pending`.
  - A second `load` while `pending` is high overwrites staging; the latest load wins.
  - The commit edge is the edge on which `cnt` wraps from DIGITS-1 to 0.
  - At the commit edge, if `pending` is set, staging is copied to the shadow registers and `pending` clears.
- **Load on the commit edge.** If `load` is high on the commit edge, the inputs go directly to the shadow registers and `pending` stays or becomes 0.
- **Blink.**
  - A free-running counter counts 0..BLINK_DIV-1. On each wrap it toggles `phase`.
  - While `phase` = 1, any digit with `sh_blink[i]` = 1 is forced dark: `an[i]` = 0 and `seg` = 0.
- **Digit lighting.** Digit i lights when `sh_en[i]` = 1, it is not blink-suppressed, and it is not blanked.
- **Dark slot.** When digit i is dark for any reason, `an` = 0 and `seg` = 8'h00 for that slot.
- **Decoder.** Standard hex-to-segment decoding:
  - 0 = 7'b1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111

## Timing
- **Reset values** (all asynchronous on `rst_` low):
  - `cnt` = 0, blink counter = 0, `phase` = 0;
  - shadow and staging registers all 0, `pending` = 0;
  - `frame_done` = 0, `seg` = 8'h00, `an` = 0.
- **Output alignment.** `seg` and `an` are registered together. After the edge on which `cnt` = k, both outputs describe digit k. `seg` never lags `an`.
- **First output after reset.** On the first edge after reset release, digit 0 is driven. Its value comes from the all-zero shadow, so it is dark because `sh_en` = 0.
- **Load latency.** The first slot showing new data is digit 0 of the frame after the commit. Worst case is DIGITS cycles from `load` to commit, plus 1 to output.
- **frame_done** is high for exactly 1 cycle in every DIGITS cycles, aligned with `an[DIGITS-1]` being driven.
- **Reset mid-frame** discards staging and returns to the reset state immediately.
- **phase timing.** `phase` toggles every BLINK_DIV cycles, independent of `cnt`. A blink edge may fall mid-frame; per-slot suppression uses `phase` as sampled that cycle.

## Configuration
- **`SEG_LZB_EN` defined:** leading-zero blanking is enabled.
  - Scanning from digit DIGITS-1 down, each digit with `sh_bin` = 0 and `sh_dp` = 0 is blanked.
  - Blanking stops at the first digit that is nonzero or has its dp set.
  - Digit 0 is never blanked.
  - The blank mask is computed combinationally from the shadow registers.
- **`SEG_LZB_EN` undefined:** no blanking; zeros display as "0".

## Test plan
- **Reset and enable:** hold `rst_` low 3 cycles, release; load `bin`=16'h1234, `en`=4'hF, `dp`=0, `blink`=0.
  - Response: `an` is 0 until the commit.
  - Then `an` cycles 0001, 0010, 0100, 1000 with `seg` 7'b0110011 (4), 1111001 (3), 1101101 (2), 0110000 (1).
  - `seg` is always aligned with `an`.
- **Mid-frame loads, latest wins:** load at `cnt`=1, then load 16'hABCD at `cnt`=2.
  - Response: `pending` is high until the wrap.
  - The old data finishes the current frame.
  - The next frame shows D, C, b, A; the first load is never displayed.
- **Load on the commit edge:** `load` high exactly at the wrap.
  - Response: new data appears in digit 0 on the next edge; `pending` stays 0.
- **Blink:** BLINK_DIV=4, `blink`=4'b0010.
  - Response: digit 1 is dark (`an`=0, `seg`=0) during the 4-cycle windows with `phase`=1.
  - The other digits are unaffected.
- **Leading-zero blanking:** `bin`=16'h0050, `en`=F.
  - With `SEG_LZB_EN`: digits 3 and 2 are dark, and "5" and "0" display.
  - With `bin`=0: only digit 0 shows "0".
  - Without the macro: all four digits light.
- **Reset mid-frame:** assert `rst_` at `cnt`=2 with `pending` = 1.
  - Response: all outputs are 0 immediately; `pending` = 0.
  - After release, the display stays dark until a new load.

Source files
------------

// File: rtl/seg_scan_n.sv
// seg_scan_n -- multiplexed seven-segment scanner for DIGITS common-select digits.
//
// Each scan clock drives one digit slot. Display data is double-buffered:
// a load goes to staging first. Staging is copied to the displayed (shadow)
// registers only when the scan wraps, so a frame never mixes old and new data.
// Each digit can blink, and seg/an are registered together.
//
// Optional feature: define SEG_LZB_EN to blank leading zeros. A leading digit
// is blanked when its nibble is 0 and its dp is off. Digit 0 is never blanked.
//
// Ports:
//   clk_1kHz    in   scan clock, one digit slot per cycle
//   rst_        in   asynchronous active-low reset
//   load        in   strobe: capture bin/dpin/en/blink
//   bin         in   4*DIGITS packed hex nibbles, digit i = bin[4i+3:4i]
//   dpin        in   DIGITS decimal points, 1 = lit
//   en          in   DIGITS digit enables, 1 = may light
//   blink       in   DIGITS blink mask, 1 = blinks
//   pending     out  staged data waiting for the next frame boundary
//   frame_done  out  high while digit DIGITS-1 is being driven
//   seg         out  {dp, a, b, c, d, e, f, g}, 1 = lit
//   an          out  DIGITS one-hot digit select, active-high (all 0 when dark)
module seg_scan_n #(
  parameter int DIGITS    = 4,
  parameter int BLINK_DIV = 500
) (
  input  logic                  clk_1kHz,
  input  logic                  rst_,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bin,
  input  logic [DIGITS-1:0]     dpin,
  input  logic [DIGITS-1:0]     en,
  input  logic [DIGITS-1:0]     blink,
  output logic                  pending,
  output logic                  frame_done,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = $clog2(DIGITS);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bdiv;
  logic                phase;
  logic                wrap;

  logic [4*DIGITS-1:0] sh_bin, st_bin;
  logic [DIGITS-1:0]   sh_dp, sh_en, sh_blink;
  logic [DIGITS-1:0]   st_dp, st_en, st_blink;

  logic [DIGITS-1:0]   blank;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_en, cur_blink, cur_blank, lit;
  logic [7:0]          seg_next;
  logic [DIGITS-1:0]   an_next;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1111110;
      4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;
      4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;
      4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;
      4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;
      4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  // The frame boundary is the edge on which the scan wraps back to digit 0.
  assign wrap = (cnt == CNT_LAST);

  // Scan counter and free-running blink divider. These two are deliberately
  // unrelated, so a phase change can land in the middle of a frame.
  always_ff @(posedge clk_1kHz or negedge rst_) begin
    if (!rst_) begin
      cnt   <= '0;
      bdiv  <= '0;
      phase <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (bdiv == BLINK_LAST) begin
        bdiv  <= '0;
        phase <= ~phase;
      end else begin
        bdiv <= bdiv + 1'b1;
      end
    end
  end

  // Staging and shadow registers. A load on the wrap edge goes straight to
  // the shadow registers, and staging is bypassed. At that edge, any older
  // staged data is superseded.
  always_ff @(posedge clk_1kHz or negedge rst_) begin
    if (!rst_) begin
      st_bin   <= '0;
      st_dp    <= '0;
      st_en    <= '0;
      st_blink <= '0;
      sh_bin   <= '0;
      sh_dp    <= '0;
      sh_en    <= '0;
      sh_blink <= '0;
      pending  <= 1'b0;
    end else if (wrap) begin
      if (load) begin
        sh_bin   <= bin;
        sh_dp    <= dpin;
        sh_en    <= en;
        sh_blink <= blink;
      end else if (pending) begin
        sh_bin   <= st_bin;
        sh_dp    <= st_dp;
        sh_en    <= st_en;
        sh_blink <= st_blink;
      end
      pending <= 1'b0;
    end else if (load) begin
      st_bin   <= bin;
      st_dp    <= dpin;
      st_en    <= en;
      st_blink <= blink;
      pending  <= 1'b1;
    end
  end

`ifdef SEG_LZB_EN
  // Walk down from the most significant digit. The zero run continues only
  // while each digit has a zero nibble and its dp is off. Digit 0 is excluded.
  always_comb begin
    logic run;
    blank = '0;
    run   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run      = run && (sh_bin[4*i +: 4] == 4'h0) && !sh_dp[i];
      blank[i] = run;
    end
  end
`else
  assign blank = '0;
`endif

  // Select the attributes of the digit in the current slot.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_blink = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt == CW'(i)) begin
        cur_nib   = sh_bin[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_en    = sh_en[i];
        cur_blink = sh_blink[i];
        cur_blank = blank[i];
      end
    end
  end

  assign lit      = cur_en && !(phase && cur_blink) && !cur_blank;
  assign seg_next = lit ? {cur_dp, hex7(cur_nib)} : 8'h00;
  assign an_next  = lit ? (DIGITS'(1) << cnt) : '0;

  // seg, an and frame_done are registered from the same slot, so they stay aligned.
  always_ff @(posedge clk_1kHz or negedge rst_) begin
    if (!rst_) begin
      seg        <= 8'h00;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next;
      an         <= an_next;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_n.sv
`timescale 1ns/1ps
module tb_seg_scan_n;
  localparam int D = 4;
  localparam int B = 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           load = 1'b0;
  logic [4*D-1:0] bin = '0;
  logic [D-1:0]   dpin = '0;
  logic [D-1:0]   en = '0;
  logic [D-1:0]   blink = '0;
  logic           pending, frame_done;
  logic [7:0]     seg;
  logic [D-1:0]   an;

  seg_scan_n #(.DIGITS(D), .BLINK_DIV(B)) dut (
    .clk_1kHz  (clk),
    .rst_      (rst_n),
    .load      (load),
    .bin       (bin),
    .dpin      (dpin),
    .en        (en),
    .blink     (blink),
    .pending   (pending),
    .frame_done(frame_done),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // The model counts clock edges since reset release. Slot = n mod D and
  // blink phase = (n / B) mod 2, both taken before the edge.
  int             n = 0;
  logic [4*D-1:0] m_bin, s_bin;
  logic [D-1:0]   m_dp, m_en, m_bl, s_dp, s_en, s_bl;
  logic           m_pend;
  logic [7:0]     e_seg;
  logic [D-1:0]   e_an;
  logic           e_fd;
  int             k, ph;
  logic           lit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit blanked(input int d);
`ifdef SEG_LZB_EN
    if (d == 0) return 1'b0;
    for (int j = d; j < D; j++)
      if (m_bin[4*j +: 4] != 4'h0 || m_dp[j]) return 1'b0;
    return 1'b1;
`else
    return (d < 0);
`endif
  endfunction

  // Model update and per-cycle compare.
  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0;
      m_bin = '0; m_dp = '0; m_en = '0; m_bl = '0;
      s_bin = '0; s_dp = '0; s_en = '0; s_bl = '0;
      m_pend = 1'b0;
      e_seg = 8'h00; e_an = '0; e_fd = 1'b0;
    end else begin
      k   = n % D;
      ph  = (n / B) % 2;
      lit = m_en[k] && !(ph == 1 && m_bl[k]) && !blanked(k);
      e_an = '0;
      e_seg = 8'h00;
      if (lit) begin
        e_an[k] = 1'b1;
        e_seg = {m_dp[k], SEG_TAB[m_bin[4*k +: 4]]};
      end
      e_fd = (k == D - 1);
      if (load && k == D - 1) begin
        m_bin = bin; m_dp = dpin; m_en = en; m_bl = blink; m_pend = 1'b0;
      end else if (load) begin
        s_bin = bin; s_dp = dpin; s_en = en; s_bl = blink; m_pend = 1'b1;
      end else if (k == D - 1 && m_pend) begin
        m_bin = s_bin; m_dp = s_dp; m_en = s_en; m_bl = s_bl; m_pend = 1'b0;
      end
      n++;
    end
    #1;
    chk("seg", seg, e_seg);
    chk("an", an, e_an);
    chk("frame_done", frame_done, e_fd);
    chk("pending", pending, m_pend);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Advance until the next edge scans slot v of a period-m cycle.
  task automatic tick_until(input int m, input int v);
    int g = 0;
    while ((n % m) != v && g < 64) begin
      tick();
      g++;
    end
    if ((n % m) != v) begin
      total++;
      bad++;
      $display("FAIL wait_slot: got %0d expected %0d", n % m, v);
    end
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d, input logic [3:0] e,
                         input logic [3:0] bl);
    bin = b; dpin = d; en = e; blink = bl; load = 1'b1;
    $display("load bin=%h dp=%b en=%b blink=%b slot=%0d", b, d, e, bl, n % D);
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_seg", seg, 8'h00);
    chk("rst_an", an, 4'h0);
    chk("rst_pending", pending, 1'b0);
    rst_n = 1'b1;

    // Reset and enable: dark until commit, then 4,3,2,1 across slots 0..3.
    do_load(16'h1234, 4'h0, 4'hF, 4'h0);
    chk("first_slot_dark", an, 4'h0);
    repeat (3) begin
      tick();
      chk("precommit_an", an, 4'h0);
    end
    tick(); chk("d0_an", an, 4'b0001); chk("d0_seg", seg, 8'h33);
    tick(); chk("d1_an", an, 4'b0010); chk("d1_seg", seg, 8'h79);
    tick(); chk("d2_an", an, 4'b0100); chk("d2_seg", seg, 8'h6D);
    tick(); chk("d3_an", an, 4'b1000); chk("d3_seg", seg, 8'h30);
    chk("d3_frame_done", frame_done, 1'b1);

    // Mid-frame loads: the latest load wins, and old data finishes the frame.
    tick_until(D, 1);
    do_load(16'hEF07, 4'h0, 4'hF, 4'h0);
    chk("mid_pending1", pending, 1'b1);
    do_load(16'hABCD, 4'h0, 4'hF, 4'h0);
    chk("mid_pending2", pending, 1'b1);
    tick(); chk("mid_old_d3", seg, 8'h30); chk("mid_pend_clr", pending, 1'b0);
    tick(); chk("mid_new_d0_an", an, 4'b0001); chk("mid_new_d0", seg, 8'h3D);
    tick(); chk("mid_new_d1", seg, 8'h4E);

    // Load on the commit edge goes directly to display.
    tick_until(D, 3);
    do_load(16'h9876, 4'b0001, 4'hF, 4'h0);
    chk("wrap_load_pending", pending, 1'b0);
    tick(); chk("wrap_load_an", an, 4'b0001); chk("wrap_load_seg", seg, 8'hDF);

    // Blink on digit 1.
    do_load(16'h1234, 4'h0, 4'hF, 4'b0010);
    repeat (8) tick();
    tick_until(2 * B, 5);
    tick(); chk("blink_dark_an", an, 4'h0); chk("blink_dark_seg", seg, 8'h00);
    tick(); chk("blink_other_an", an, 4'b0100);
    tick_until(2 * B, 1);
    tick(); chk("blink_lit_an", an, 4'b0010); chk("blink_lit_seg", seg, 8'h79);

    // Leading-zero blanking.
    do_load(16'h0050, 4'h0, 4'hF, 4'h0);
    repeat (8) tick();
    tick_until(D, 3);
    tick();
`ifdef SEG_LZB_EN
    chk("lzb_d3_an", an, 4'h0);
    chk("lzb_d3_seg", seg, 8'h00);
`else
    chk("lzb_d3_an", an, 4'b1000);
    chk("lzb_d3_seg", seg, 8'h7E);
`endif
    tick_until(D, 1);
    tick(); chk("lzb_d1_seg", seg, 8'h5B);
    do_load(16'h0000, 4'h0, 4'hF, 4'h0);
    repeat (8) tick();
    tick_until(D, 1);
    tick();
`ifdef SEG_LZB_EN
    chk("lzb0_d1_an", an, 4'h0);
`else
    chk("lzb0_d1_an", an, 4'b0010);
`endif
    tick_until(D, 0);
    tick(); chk("lzb0_d0_an", an, 4'b0001); chk("lzb0_d0_seg", seg, 8'h7E);

    // Exercise the remaining decoder entries.
    do_load(16'hFE8A, 4'b1010, 4'hF, 4'h0);
    repeat (8) tick();

    // Reset mid-frame with pending set.
    tick_until(D, 1);
    do_load(16'h4321, 4'h0, 4'hF, 4'h0);
    chk("rstmid_pending_pre", pending, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_seg", seg, 8'h00);
    chk("rstmid_an", an, 4'h0);
    chk("rstmid_pending", pending, 1'b0);
    chk("rstmid_fd", frame_done, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) begin
      tick();
      chk("post_rst_dark", an, 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
